// File: rtl/fp_add_normalize_pkg.sv
// Shared constants and FSM state type for the bfloat16 add/normalize stage.
package fp_add_normalize_pkg;

    localparam int EW = 8;  // exponent width
    localparam int MW = 7;  // stored mantissa width (datapath is MW+1 with hidden bit)

    // All-ones exponent: infinity when produced by a carry-out increment
    localparam logic [EW-1:0] EXP_INF = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp_add_normalize_mant_addsub.sv
// Combinational mantissa add / magnitude-subtract with operand swap.
// Same signs add with carry-out; opposite signs subtract the smaller magnitude
// from the larger and take the sign of the larger.
module fp_add_normalize_mant_addsub
    import fp_add_normalize_pkg::*;
(
    input  logic [MW:0] a,
    input  logic [MW:0] b,
    input  logic        a_sign,
    input  logic        b_sign,
    output logic        carry,
    output logic [MW:0] sum,
    output logic        sign,
    output logic        zero
);

    logic          eff_sub;
    logic          a_ge_b;
    logic [MW+1:0] add_full;
    logic [MW:0]   diff;

    // Adder, comparator and swap mux feeding the result select
    always_comb begin
        eff_sub  = a_sign ^ b_sign;
        a_ge_b   = (a >= b);
        add_full = {1'b0, a} + {1'b0, b};
        diff     = a_ge_b ? (a - b) : (b - a);

        if (eff_sub) begin
            carry = 1'b0;
            sum   = diff;
            sign  = a_ge_b ? a_sign : b_sign;
        end else begin
            carry = add_full[MW+1];
            sum   = add_full[MW:0];
            sign  = a_sign;
        end

        zero = !carry && (sum == '0);
    end

endmodule

// File: rtl/fp_add_normalize.sv
// bfloat16 adder back end: mantissa add/subtract, iterative left-shift
// normalization with exponent tracking, and valid/ready result handoff.
module fp_add_normalize
    import fp_add_normalize_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             Ps,
    input  logic             Qs,
    input  logic [EW-1:0]    Pe,
    input  logic [MW:0]      Pm,
    input  logic [MW:0]      Qm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   result
);

    state_t        state;

    // Captured operands
    logic          ps_r;
    logic          qs_r;
    logic [EW-1:0] pe_r;
    logic [MW:0]   pm_r;
    logic [MW:0]   qm_r;

    // Working sign / exponent / mantissa
    logic          sign_r;
    logic [EW-1:0] e_r;
    logic [MW:0]   m_r;

    // Add/subtract unit outputs
    logic          as_carry;
    logic [MW:0]   as_sum;
    logic          as_sign;
    logic          as_zero;

    // ADD-state next values
    logic          add_sign;
    logic [EW-1:0] add_e;
    logic [MW:0]   add_m;
    logic [EW-1:0] e_inc;
    state_t        add_next;

    // NORM-state next values
    logic          norm_sign;
    logic [EW-1:0] norm_e;
    logic [MW:0]   norm_m;
    state_t        norm_next;

    fp_add_normalize_mant_addsub u_addsub (
        .a      (pm_r),
        .b      (qm_r),
        .a_sign (ps_r),
        .b_sign (qs_r),
        .carry  (as_carry),
        .sum    (as_sum),
        .sign   (as_sign),
        .zero   (as_zero)
    );

    // ADD step: carry renormalization, overflow to infinity, exact zero
    always_comb begin
        e_inc    = pe_r + EW'(1);
        add_sign = as_sign;
        add_e    = pe_r;
        add_m    = as_sum;
        add_next = NORM;

        if (as_carry) begin
            add_m = {1'b1, as_sum[MW:1]};
            add_e = e_inc;
        end

        if (as_carry && (e_inc == EXP_INF)) begin
            add_m    = '0;
            add_next = DONE;
        end else if (as_zero) begin
            add_sign = 1'b0;
            add_e    = '0;
            add_m    = '0;
            add_next = DONE;
        end else if (add_m[MW]) begin
            add_next = DONE;
        end
    end

    // NORM step: one left shift per cycle, flush to signed zero at the exponent floor.
    // Exit looks ahead at the bit being shifted into the hidden position so the
    // final shift lands directly in DONE (keeps worst-case latency at MW+2).
    always_comb begin
        norm_sign = sign_r;
        norm_e    = e_r;
        norm_m    = m_r;
        norm_next = NORM;

        if (m_r[MW]) begin
            norm_next = DONE;
        end else if (e_r > EW'(1)) begin
            norm_m = {m_r[MW-1:0], 1'b0};
            norm_e = e_r - EW'(1);
            if (m_r[MW-1]) begin
                norm_next = DONE;
            end
        end else begin
            norm_e    = '0;
            norm_m    = '0;
            norm_next = DONE;
        end
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ps_r      <= 1'b0;
            qs_r      <= 1'b0;
            pe_r      <= '0;
            pm_r      <= '0;
            qm_r      <= '0;
            sign_r    <= 1'b0;
            e_r       <= '0;
            m_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        ps_r     <= Ps;
                        qs_r     <= Qs;
                        pe_r     <= Pe;
                        pm_r     <= Pm;
                        qm_r     <= Qm;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    sign_r <= add_sign;
                    e_r    <= add_e;
                    m_r    <= add_m;
                    state  <= add_next;
                    if (add_next == DONE) begin
                        out_valid <= 1'b1;
                        result    <= {add_sign, add_e, add_m[MW-1:0]};
                    end
                end
                NORM: begin
                    sign_r <= norm_sign;
                    e_r    <= norm_e;
                    m_r    <= norm_m;
                    state  <= norm_next;
                    if (norm_next == DONE) begin
                        out_valid <= 1'b1;
                        result    <= {norm_sign, norm_e, norm_m[MW-1:0]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed testbench for fp_add_normalize.
module tb_fp_add_normalize;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        Ps;
    logic        Qs;
    logic [7:0]  Pe;
    logic [7:0]  Pm;
    logic [7:0]  Qm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ps;
        logic        qs;
        logic [7:0]  pe;
        logic [7:0]  pm;
        logic [7:0]  qm;
        logic [15:0] res;
        int          lat;
    } vec_t;

    fp_add_normalize dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ps        (Ps),
        .Qs        (Qs),
        .Pe        (Pe),
        .Pm        (Pm),
        .Qm        (Qm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand set for a single accept edge; call #1 after an edge in IDLE
    task automatic drive_op(input vec_t v);
        Ps       = v.ps;
        Qs       = v.qs;
        Pe       = v.pe;
        Pm       = v.pm;
        Qm       = v.qm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counted with the accept cycle as cycle 1; bounded wait
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Ps = 1'b0; Qs = 1'b0; Pe = '0; Pm = '0; Qm = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result got %h want 0000", result);
        end
    endtask

    task automatic test_add();
        vec_t v[5];
        int   lat;
        v[0] = '{1'b0, 1'b0, 8'd127, 8'h80, 8'h80, 16'h4000, 2}; // 1.0+1.0 carry
        v[1] = '{1'b1, 1'b1, 8'd100, 8'h80, 8'h20, 16'hB220, 2}; // no carry, negative
        v[2] = '{1'b1, 1'b1, 8'd130, 8'hC0, 8'hC0, 16'hC1C0, 2}; // carry, negative
        v[3] = '{1'b0, 1'b0, 8'd127, 8'h81, 8'h80, 16'h4000, 2}; // carry truncates lsb
        v[4] = '{1'b0, 1'b0, 8'd254, 8'hFF, 8'hFF, 16'h7F80, 2}; // overflow to inf
        for (int i = 0; i < 5; i++) begin
            drive_op(v[i]);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL add%0d_busy in_ready got %b want 0", i, in_ready);
            end
            wait_out(lat);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL add%0d_timeout out_valid got %b want 1", i, out_valid);
            end
            checks++;
            if (result !== v[i].res) begin
                errors++;
                $display("FAIL add%0d_result got %h want %h", i, result, v[i].res);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("FAIL add%0d_latency got %0d want %0d", i, lat, v[i].lat);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL add%0d_pop valid/ready got %b%b want 01", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_sub();
        vec_t v[5];
        int   lat;
        v[0] = '{1'b0, 1'b1, 8'd127, 8'hC0, 8'h80, 16'h3F00, 3}; // 1.5-1.0, one shift
        v[1] = '{1'b0, 1'b1, 8'd127, 8'h80, 8'hC0, 16'hBF00, 3}; // swap, sign of Q
        v[2] = '{1'b1, 1'b0, 8'd127, 8'hA0, 8'hA0, 16'h0000, 2}; // exact cancel -> +0
        v[3] = '{1'b0, 1'b1, 8'd2,   8'h81, 8'h80, 16'h0000, 4}; // underflow flush
        v[4] = '{1'b0, 1'b1, 8'd127, 8'h80, 8'h7F, 16'h3C00, 9}; // seven shifts, max latency
        for (int i = 0; i < 5; i++) begin
            drive_op(v[i]);
            wait_out(lat);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sub%0d_timeout out_valid got %b want 1", i, out_valid);
            end
            checks++;
            if (result !== v[i].res) begin
                errors++;
                $display("FAIL sub%0d_result got %h want %h", i, result, v[i].res);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("FAIL sub%0d_latency got %0d want %0d", i, lat, v[i].lat);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sub%0d_pop valid/ready got %b%b want 01", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t v;
        int   lat;
        v = '{1'b1, 1'b1, 8'd130, 8'hC0, 8'hC0, 16'hC1C0, 2};
        out_ready = 1'b0;
        drive_op(v);
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout out_valid got %b want 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'hC1C0) begin
                errors++;
                $display("FAIL bp_hold%0d valid/ready/result got %b%b %h want 10 c1c0",
                         i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release valid/ready got %b%b want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_in_norm();
        vec_t v;
        vec_t r;
        int   lat;
        bit   saw_valid;
        v = '{1'b0, 1'b1, 8'd127, 8'h80, 8'h7F, 16'h3C00, 9};
        drive_op(v);
        repeat (2) @(posedge clk);   // now in NORM, mid-shift
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstnorm_async valid/ready got %b%b want 01", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstnorm_no_output saw_valid %b in_ready %b want 0 1", saw_valid, in_ready);
        end
        r = '{1'b0, 1'b1, 8'd127, 8'hC0, 8'h80, 16'h3F00, 3};
        drive_op(r);
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h3F00 || lat !== 3) begin
            errors++;
            $display("FAIL rstnorm_recover valid %b result %h lat %0d want 1 3f00 3",
                     out_valid, result, lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_in_norm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
